// File: rtl/fpga_pb_reader.sv
// Pushbutton reader: synchronizes and debounces 21 buttons, queues press events
// in a small FIFO and exposes STATUS/KEY/LEVEL registers on a CPU I/O page.
module fpga_pb_reader #(
  parameter int unsigned TICK_CYCLES = 1000,
  parameter int unsigned FIFO_DEPTH  = 4
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic [20:0] pb,
  input  logic        read_en,
  input  logic [7:0]  addr,
  input  logic [7:0]  din,
  output logic [7:0]  dout,
  output logic        irq
);

  localparam int unsigned NUM_PB = 21;
  localparam int unsigned TICK_W = 16;
  localparam int unsigned CODE_W = 5;
  localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W  = PTR_W + 1;

  localparam logic [7:0] ADDR_STATUS = 8'h20;
  localparam logic [7:0] ADDR_KEY    = 8'h21;
  localparam logic [7:0] ADDR_LEVEL0 = 8'h22;
  localparam logic [7:0] ADDR_LEVEL1 = 8'h23;
  localparam logic [7:0] ADDR_LEVEL2 = 8'h24;

  logic [NUM_PB-1:0]      sync1_q, sync1_d;
  logic [NUM_PB-1:0]      sync2_q, sync2_d;
  logic [TICK_W-1:0]      tick_cnt_q, tick_cnt_d;
  logic                   tick_c;
  logic [NUM_PB-1:0]      deb_q, deb_d;
  logic [NUM_PB-1:0][1:0] agree_q, agree_d;
  logic [NUM_PB-1:0]      rise_q, rise_d;
  logic [NUM_PB-1:0]      pend_q, pend_d;
  logic                   ovf_q, ovf_d;

  logic [FIFO_DEPTH-1:0][CODE_W-1:0] mem_q, mem_d;
  logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]       count_q, count_d;

  logic                   grant_c;
  logic [CODE_W-1:0]      grant_idx_c;
  logic                   full_c;
  logic                   empty_c;
  logic                   pop_c;
  logic                   push_c;
  logic                   ovf_clr_c;
  logic                   ovf_set_c;
  logic                   unused_din;

  assign unused_din = ^din[6:0];

  // Two-flop synchronizer in front of everything else.
  always_comb begin
    sync1_d = pb;
    sync2_d = sync1_q;
  end

  // Free-running sample tick; first pulse TICK_CYCLES cycles after reset.
  always_comb begin
    tick_c     = (tick_cnt_q == TICK_W'(TICK_CYCLES - 1));
    tick_cnt_d = tick_c ? '0 : tick_cnt_q + TICK_W'(1);
  end

  // Three consecutive disagreeing samples flip the debounced state.
  always_comb begin
    deb_d   = deb_q;
    agree_d = agree_q;
    rise_d  = '0;
    if (tick_c) begin
      for (int i = 0; i < NUM_PB; i++) begin
        if (sync2_q[i] != deb_q[i]) begin
          if (agree_q[i] == 2'd2) begin
            deb_d[i]   = sync2_q[i];
            agree_d[i] = 2'd0;
            rise_d[i]  = sync2_q[i];
          end else begin
            agree_d[i] = agree_q[i] + 2'd1;
          end
        end else begin
          agree_d[i] = 2'd0;
        end
      end
    end
  end

  // Lowest-index pending button wins the FIFO slot.
  always_comb begin
    grant_c     = 1'b0;
    grant_idx_c = '0;
    for (int i = NUM_PB - 1; i >= 0; i--) begin
      if (pend_q[i]) begin
        grant_c     = 1'b1;
        grant_idx_c = CODE_W'(i);
      end
    end
  end

  always_comb begin
    full_c    = (count_q == CNT_W'(FIFO_DEPTH));
    empty_c   = (count_q == '0);
    pop_c     = read_en && (addr == ADDR_KEY) && !empty_c;
    push_c    = grant_c && (!full_c || pop_c);
    ovf_clr_c = !read_en && (addr == ADDR_STATUS) && din[7];
    ovf_set_c = |(rise_q & pend_q);
  end

  // Pending bits: a press onto an already-pending button is dropped.
  always_comb begin
    pend_d = pend_q;
    if (push_c) begin
      pend_d[grant_idx_c] = 1'b0;
    end
    pend_d = pend_d | (rise_q & ~pend_q);

    ovf_d = ovf_q;
    if (ovf_clr_c) begin
      ovf_d = 1'b0;
    end
    if (ovf_set_c) begin
      ovf_d = 1'b1;
    end
  end

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_c) begin
      mem_d[wr_ptr_q] = grant_idx_c;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop_c) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    if (push_c && !pop_c) begin
      count_d = count_q + CNT_W'(1);
    end else if (!push_c && pop_c) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  // CPU read mux reflects pre-edge state; zero unless reading.
  always_comb begin
    dout = 8'h00;
    if (read_en) begin
      case (addr)
        ADDR_STATUS: dout = {ovf_q, 2'b00, 5'(count_q)};
        ADDR_KEY: begin
          if (!empty_c) begin
            dout = {1'b1, 2'b00, mem_q[rd_ptr_q]};
          end
        end
        ADDR_LEVEL0: dout = deb_q[7:0];
        ADDR_LEVEL1: dout = deb_q[15:8];
        ADDR_LEVEL2: dout = {3'b000, deb_q[20:16]};
        default:     dout = 8'h00;
      endcase
    end
  end

  assign irq = !empty_c;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      tick_cnt_q <= '0;
      deb_q      <= '0;
      agree_q    <= '0;
      rise_q     <= '0;
      pend_q     <= '0;
      ovf_q      <= 1'b0;
      mem_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      tick_cnt_q <= tick_cnt_d;
      deb_q      <= deb_d;
      agree_q    <= agree_d;
      rise_q     <= rise_d;
      pend_q     <= pend_d;
      ovf_q      <= ovf_d;
      mem_q      <= mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
    end
  end

endmodule

// File: tb/tb_fpga_pb_reader.sv
// Bench for fpga_pb_reader: directed scenarios plus randomized traffic checked
// against a queue-based reference model of the button/FIFO behaviour.
module tb_fpga_pb_reader;

  localparam int unsigned TICK  = 4;
  localparam int unsigned DEPTH = 4;

  logic        clk;
  logic        nrst;
  logic [20:0] pb;
  logic        read_en;
  logic [7:0]  addr;
  logic [7:0]  din;
  logic [7:0]  dout;
  logic        irq;

  int n_cmp;
  int n_bad;

  fpga_pb_reader #(.TICK_CYCLES(TICK), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .nrst(nrst), .pb(pb), .read_en(read_en),
    .addr(addr), .din(din), .dout(dout), .irq(irq)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Reference model state
  logic [20:0] m_h1, m_h2, m_deb, m_pend, m_rise;
  int          m_agree [21];
  int          m_edge;
  logic        m_ovf;
  logic [4:0]  m_q [$];

  task automatic model_reset();
    m_h1 = '0; m_h2 = '0; m_deb = '0; m_pend = '0; m_rise = '0;
    for (int i = 0; i < 21; i++) m_agree[i] = 0;
    m_edge = 0;
    m_ovf  = 1'b0;
    m_q.delete();
  endtask

  // One rising edge of the specified behaviour, using pre-edge inputs.
  task automatic model_step();
    logic [20:0] samp, pend0, rise_next;
    bit pop, set_ovf;
    int g;
    if (!nrst) begin
      model_reset();
      return;
    end
    pend0   = m_pend;
    set_ovf = 1'b0;
    pop = read_en && (addr == 8'h21) && (m_q.size() != 0);
    if (pop) void'(m_q.pop_front());
    g = -1;
    for (int i = 20; i >= 0; i--) if (pend0[i]) g = i;
    if (g >= 0 && m_q.size() < DEPTH) begin
      m_q.push_back(5'(g));
      m_pend[g] = 1'b0;
    end
    for (int i = 0; i < 21; i++) begin
      if (m_rise[i]) begin
        if (pend0[i]) set_ovf = 1'b1;
        else m_pend[i] = 1'b1;
      end
    end
    if (!read_en && addr == 8'h20 && din[7]) m_ovf = 1'b0;
    if (set_ovf) m_ovf = 1'b1;
    m_edge++;
    samp = m_h2;
    m_h2 = m_h1;
    m_h1 = pb;
    rise_next = '0;
    if (m_edge % TICK == 0) begin
      for (int i = 0; i < 21; i++) begin
        if (samp[i] != m_deb[i]) begin
          m_agree[i]++;
          if (m_agree[i] == 3) begin
            m_deb[i]     = samp[i];
            m_agree[i]   = 0;
            rise_next[i] = samp[i];
          end
        end else begin
          m_agree[i] = 0;
        end
      end
    end
    m_rise = rise_next;
  endtask

  function automatic logic [7:0] exp_dout();
    logic [7:0] r;
    r = 8'h00;
    if (read_en) begin
      case (addr)
        8'h20: r = {m_ovf, 2'b00, 5'(m_q.size())};
        8'h21: if (m_q.size() != 0) r = {3'b100, m_q[0]};
        8'h22: r = m_deb[7:0];
        8'h23: r = m_deb[15:8];
        8'h24: r = {3'b000, m_deb[20:16]};
        default: r = 8'h00;
      endcase
    end
    return r;
  endfunction

  function automatic logic exp_irq();
    return m_q.size() != 0;
  endfunction

  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic idle(input int n);
    read_en = 1'b0; addr = 8'h00; din = 8'h00;
    repeat (n) cyc();
  endtask

  task automatic press(input logic [20:0] mask);
    pb = mask;
    idle(20);
    pb = '0;
    idle(30);
  endtask

  task automatic test_reset();
    nrst = 1'b0;
    model_reset();
    read_en = 1'b1;
    pb = 21'($urandom);
    repeat (2) cyc();
    for (int a = 32; a <= 36; a++) begin
      addr = 8'(a);
      #1;
      n_cmp++;
      if (dout !== 8'h00 || irq !== 1'b0) begin
        n_bad++;
        $display("FAIL reset_hold addr=%02h: got dout=%02h irq=%b, want dout=00 irq=0", addr, dout, irq);
      end
    end
    pb = '0;
    idle(1);
    nrst = 1'b1;
    read_en = 1'b1; addr = 8'h20;
    #1;
    n_cmp++;
    if (dout !== exp_dout() || irq !== exp_irq() || dout !== 8'h00) begin
      n_bad++;
      $display("FAIL reset_release: got dout=%02h irq=%b, want dout=00 irq=0", dout, irq);
    end
    idle(2);
  endtask

  task automatic test_single_press();
    pb = '0; pb[5] = 1'b1;
    read_en = 1'b1; addr = 8'h22;
    for (int c = 0; c < 20; c++) begin
      cyc();
      n_cmp++;
      if (dout !== exp_dout() || irq !== exp_irq()) begin
        n_bad++;
        $display("FAIL single_hold cyc=%0d: got dout=%02h irq=%b, want dout=%02h irq=%b", c, dout, irq, exp_dout(), exp_irq());
      end
    end
    n_cmp++;
    if (dout !== 8'h20) begin
      n_bad++;
      $display("FAIL single_level0: got %02h, want 20", dout);
    end
    pb = '0;
    idle(30);
    n_cmp++;
    if (irq !== 1'b1) begin
      n_bad++;
      $display("FAIL single_irq: got irq=%b, want 1", irq);
    end
    read_en = 1'b1; addr = 8'h21;
    #1;
    n_cmp++;
    if (dout !== 8'h85 || dout !== exp_dout()) begin
      n_bad++;
      $display("FAIL single_key: got %02h, want 85", dout);
    end
    cyc();
    read_en = 1'b1; addr = 8'h20;
    #1;
    n_cmp++;
    if (irq !== 1'b0 || dout !== 8'h00) begin
      n_bad++;
      $display("FAIL single_after_pop: got irq=%b status=%02h, want irq=0 status=00", irq, dout);
    end
    idle(2);
  endtask

  task automatic test_bounce();
    pb = '0;
    read_en = 1'b1; addr = 8'h22;
    for (int c = 0; c < 40; c++) begin
      pb[3] = ((c / 3) % 2 == 0);
      cyc();
      n_cmp++;
      if (dout[3] !== 1'b0 || dout !== exp_dout() || irq !== exp_irq()) begin
        n_bad++;
        $display("FAIL bounce cyc=%0d: got level0=%02h irq=%b, want level0=%02h irq=%b", c, dout, irq, exp_dout(), exp_irq());
      end
    end
    pb = '0;
    idle(20);
    read_en = 1'b1; addr = 8'h20;
    #1;
    n_cmp++;
    if (irq !== 1'b0 || dout !== 8'h00) begin
      n_bad++;
      $display("FAIL bounce_no_event: got irq=%b status=%02h, want irq=0 status=00", irq, dout);
    end
    idle(1);
  endtask

  task automatic test_simultaneous();
    logic [7:0] want [3];
    want = '{8'h80, 8'h89, 8'h94};
    press(21'h10_0201);
    for (int k = 0; k < 3; k++) begin
      read_en = 1'b1; addr = 8'h21;
      #1;
      n_cmp++;
      if (dout !== want[k] || dout !== exp_dout()) begin
        n_bad++;
        $display("FAIL simul_key%0d: got %02h, want %02h", k, dout, want[k]);
      end
      cyc();
    end
    read_en = 1'b0; addr = 8'h00;
    #1;
    n_cmp++;
    if (irq !== 1'b0) begin
      n_bad++;
      $display("FAIL simul_drained: got irq=%b, want 0", irq);
    end
    idle(1);
  endtask

  task automatic test_overflow();
    logic [7:0] want [4];
    want = '{8'h84, 8'h87, 8'h8C, 8'h90};
    press(21'h01_1092);
    read_en = 1'b1; addr = 8'h20;
    #1;
    n_cmp++;
    if (dout !== 8'h04 || dout !== exp_dout()) begin
      n_bad++;
      $display("FAIL ovfl_full_status: got %02h, want 04", dout);
    end
    addr = 8'h21;
    #1;
    n_cmp++;
    if (dout !== 8'h81) begin
      n_bad++;
      $display("FAIL ovfl_first_key: got %02h, want 81", dout);
    end
    cyc();
    addr = 8'h20;
    #1;
    n_cmp++;
    if (dout !== 8'h04 || dout !== exp_dout()) begin
      n_bad++;
      $display("FAIL ovfl_refill_status: got %02h, want 04", dout);
    end
    for (int k = 0; k < 4; k++) begin
      addr = 8'h21;
      #1;
      n_cmp++;
      if (dout !== want[k] || dout !== exp_dout()) begin
        n_bad++;
        $display("FAIL ovfl_key%0d: got %02h, want %02h", k, dout, want[k]);
      end
      cyc();
    end
    addr = 8'h20;
    #1;
    n_cmp++;
    if (dout !== 8'h00) begin
      n_bad++;
      $display("FAIL ovfl_empty_status: got %02h, want 00", dout);
    end
    idle(1);
  endtask

  task automatic test_ovf_clear();
    logic [7:0] want [5];
    want = '{8'h8A, 8'h8B, 8'h8C, 8'h8D, 8'h82};
    press(21'h00_3C00);
    press(21'h00_0004);
    press(21'h00_0004);
    read_en = 1'b1; addr = 8'h20;
    #1;
    n_cmp++;
    if (dout !== 8'h84 || dout !== exp_dout()) begin
      n_bad++;
      $display("FAIL ovf_set: got %02h, want 84", dout);
    end
    read_en = 1'b0; din = 8'h7F;
    cyc();
    read_en = 1'b1;
    #1;
    n_cmp++;
    if (dout !== 8'h84) begin
      n_bad++;
      $display("FAIL ovf_ignored_write: got %02h, want 84", dout);
    end
    read_en = 1'b0; din = 8'h80;
    cyc();
    read_en = 1'b1; din = 8'h00;
    #1;
    n_cmp++;
    if (dout !== 8'h04 || dout !== exp_dout()) begin
      n_bad++;
      $display("FAIL ovf_clear: got %02h, want 04", dout);
    end
    for (int k = 0; k < 5; k++) begin
      addr = 8'h21;
      #1;
      n_cmp++;
      if (dout !== want[k] || dout !== exp_dout()) begin
        n_bad++;
        $display("FAIL ovf_drain%0d: got %02h, want %02h", k, dout, want[k]);
      end
      cyc();
    end
    idle(1);
  endtask

  task automatic test_reset_mid();
    press(21'h00_0148);
    read_en = 1'b1; addr = 8'h20;
    #1;
    n_cmp++;
    if (dout !== 8'h03 || dout !== exp_dout()) begin
      n_bad++;
      $display("FAIL rstmid_queued: got %02h, want 03", dout);
    end
    pb = 21'h00_0001;
    read_en = 1'b0; addr = 8'h00;
    repeat (14) cyc();
    #2;
    nrst = 1'b0;
    model_reset();
    #1;
    n_cmp++;
    if (irq !== 1'b0) begin
      n_bad++;
      $display("FAIL rstmid_irq_low: got irq=%b, want 0", irq);
    end
    cyc();
    pb = '0;
    nrst = 1'b1;
    read_en = 1'b1; addr = 8'h20;
    #1;
    n_cmp++;
    if (dout !== 8'h00 || irq !== 1'b0) begin
      n_bad++;
      $display("FAIL rstmid_status: got status=%02h irq=%b, want 00 0", dout, irq);
    end
    addr = 8'h21;
    #1;
    n_cmp++;
    if (dout !== 8'h00) begin
      n_bad++;
      $display("FAIL rstmid_key: got %02h, want 00", dout);
    end
    read_en = 1'b0;
    repeat (20) cyc();
    read_en = 1'b1; addr = 8'h20;
    #1;
    n_cmp++;
    if (dout !== 8'h00 || irq !== 1'b0 || dout !== exp_dout()) begin
      n_bad++;
      $display("FAIL rstmid_no_partial: got status=%02h irq=%b, want 00 0", dout, irq);
    end
    idle(1);
  endtask

  task automatic test_random();
    int seg_left;
    int k;
    seg_left = 0;
    for (int c = 0; c < 1600; c++) begin
      if (seg_left == 0) begin
        pb = 21'($urandom & $urandom);
        seg_left = $urandom_range(1, 30);
      end
      seg_left--;
      read_en = ($urandom_range(0, 3) != 0);
      k = $urandom_range(0, 7);
      case (k)
        0, 1, 7: addr = 8'h20;
        2:       addr = 8'h21;
        3, 4, 5: addr = 8'(8'h22 + k - 3);
        default: addr = 8'($urandom);
      endcase
      if ((c / 200) % 2 == 0 && addr == 8'h21) addr = 8'h22;
      din = 8'($urandom);
      if (c == 700) begin
        nrst = 1'b0;
        model_reset();
      end
      if (c == 704) nrst = 1'b1;
      #1;
      n_cmp++;
      if (dout !== exp_dout() || irq !== exp_irq()) begin
        n_bad++;
        $display("FAIL random cyc=%0d addr=%02h rd=%b: got dout=%02h irq=%b, want dout=%02h irq=%b",
                 c, addr, read_en, dout, irq, exp_dout(), exp_irq());
      end
      cyc();
    end
    pb = '0;
    idle(2);
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    nrst = 1'b0; pb = '0; read_en = 1'b0; addr = 8'h00; din = 8'h00;
    model_reset();
    test_reset();
    test_single_press();
    test_bounce();
    test_simultaneous();
    test_overflow();
    test_ovf_clear();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
